reg_writeback_unit: RTL and testbench

Write-side front end of the 32 x 32 register file. It merges results from the single-cycle ALU pipeline and the multi-cycle M-extension (mul/div) unit onto the register file's single write port (WRITE_DATA / WRITE_ADDRESS / WRITE_ENABLE). It buffers mul/div results in a small FIFO and keeps a per-register pending scoreboard that decode uses for RAW/WAW stalls.

---
 rtl/reg_writeback_unit_if.sv | 36 +++
 rtl/reg_writeback_unit.sv | 127 ++++++++++++
 tb/tb_reg_writeback_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/reg_writeback_unit_if.sv
// Signal bundle between the ALU / mul-div pipelines, decode and the register
// file write port.
interface reg_writeback_unit_if;
    logic        ALU_VALID;
    logic [4:0]  ALU_RD;
    logic [31:0] ALU_DATA;
    logic        MUL_VALID;
    logic        MUL_READY;
    logic [4:0]  MUL_RD;
    logic [31:0] MUL_DATA;
    logic        ISSUE_VALID;
    logic [4:0]  ISSUE_RD;
    logic [4:0]  QUERY_ADDR1;
    logic [4:0]  QUERY_ADDR2;
    logic        PENDING1;
    logic        PENDING2;
    logic [31:0] BUSY_MASK;
    logic [31:0] WRITE_DATA;
    logic [4:0]  WRITE_ADDRESS;
    logic        WRITE_ENABLE;
    logic        WAW_ERR;

    modport master (
        output ALU_VALID, ALU_RD, ALU_DATA, MUL_VALID, MUL_RD, MUL_DATA,
               ISSUE_VALID, ISSUE_RD, QUERY_ADDR1, QUERY_ADDR2,
        input  MUL_READY, PENDING1, PENDING2, BUSY_MASK,
               WRITE_DATA, WRITE_ADDRESS, WRITE_ENABLE, WAW_ERR
    );

    modport slave (
        input  ALU_VALID, ALU_RD, ALU_DATA, MUL_VALID, MUL_RD, MUL_DATA,
               ISSUE_VALID, ISSUE_RD, QUERY_ADDR1, QUERY_ADDR2,
        output MUL_READY, PENDING1, PENDING2, BUSY_MASK,
               WRITE_DATA, WRITE_ADDRESS, WRITE_ENABLE, WAW_ERR
    );
endinterface

// File: rtl/reg_writeback_unit.sv
// Merges ALU and mul/div results onto the single register-file write port,
// buffering mul/div results and tracking outstanding mul/div destinations.
module reg_writeback_unit #(
    parameter int FIFO_DEPTH = 2,
    parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input logic                CLK,
    input logic                RESET,
    reg_writeback_unit_if.slave wb
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
    logic [4:0]       fifo_rd_d   [FIFO_DEPTH];
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [31:0]      fifo_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      busy_q, busy_d;
    logic             we_q, we_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             waw_q, waw_d;

    logic        mul_ready, alu_sel, push, pop, pop_wr, issue;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    // Readiness depends on state only, so a full FIFO refuses a push even
    // in the cycle it pops.
    assign mul_ready = (count_q != FULL_CNT);

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        busy_d      = busy_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        waw_d       = waw_q;

        alu_sel   = wb.ALU_VALID && (wb.ALU_RD != 5'd0);
        push      = wb.MUL_VALID && mul_ready;
        pop       = !alu_sel && (count_q != '0);
        head_rd   = fifo_rd_q[rd_ptr_q];
        head_data = fifo_data_q[rd_ptr_q];
        pop_wr    = pop && (head_rd != 5'd0);
        issue     = wb.ISSUE_VALID && (wb.ISSUE_RD != 5'd0);

        if (push) begin
            fifo_rd_d[wr_ptr_q]   = wb.MUL_RD;
            fifo_data_d[wr_ptr_q] = wb.MUL_DATA;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        if (alu_sel) begin
            we_d    = 1'b1;
            waddr_d = wb.ALU_RD;
            wdata_d = wb.ALU_DATA;
        end else if (pop_wr) begin
            we_d    = 1'b1;
            waddr_d = head_rd;
            wdata_d = head_data;
        end

        // Clear first so a same-cycle issue to the same register wins.
        if (pop_wr)
            busy_d[head_rd] = 1'b0;
        if (issue)
            busy_d[wb.ISSUE_RD] = 1'b1;
        busy_d[0] = 1'b0;

        if ((alu_sel && busy_q[wb.ALU_RD]) || (issue && busy_q[wb.ISSUE_RD]))
            waw_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            waw_q    <= 1'b0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            waw_q       <= waw_d;
        end
    end

    assign wb.MUL_READY     = mul_ready;
    assign wb.BUSY_MASK     = busy_q;
    assign wb.PENDING1      = busy_q[wb.QUERY_ADDR1];
    assign wb.PENDING2      = busy_q[wb.QUERY_ADDR2];
    assign wb.WRITE_ENABLE  = we_q;
    assign wb.WRITE_ADDRESS = waddr_q;
    assign wb.WRITE_DATA    = wdata_q;
    assign wb.WAW_ERR       = waw_q;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed-vector bench for reg_writeback_unit with hand-computed expectations.
module tb_reg_writeback_unit;

    logic CLK = 1'b0;
    logic RESET;
    int   n_vec = 0;
    int   n_err = 0;

    reg_writeback_unit_if wb ();

    reg_writeback_unit #(.FIFO_DEPTH(2), .PTR_W(1)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .wb    (wb.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs set after this are sampled at the next edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        wb.ALU_VALID   = 1'b0; wb.ALU_RD = '0; wb.ALU_DATA = '0;
        wb.MUL_VALID   = 1'b0; wb.MUL_RD = '0; wb.MUL_DATA = '0;
        wb.ISSUE_VALID = 1'b0; wb.ISSUE_RD = '0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        wb.ALU_VALID = 1'b1; wb.ALU_RD = rd; wb.ALU_DATA = d;
    endtask

    task automatic mul(input logic [4:0] rd, input logic [31:0] d);
        wb.MUL_VALID = 1'b1; wb.MUL_RD = rd; wb.MUL_DATA = d;
    endtask

    task automatic wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".we"},   32'(wb.WRITE_ENABLE),  32'(we));
        chk({tag, ".addr"}, 32'(wb.WRITE_ADDRESS), 32'(a));
        chk({tag, ".data"}, wb.WRITE_DATA,         d);
    endtask

    initial begin
        RESET = 1'b0;
        idle_inputs();
        wb.QUERY_ADDR1 = '0;
        wb.QUERY_ADDR2 = '0;
        step(); step();
        wr("rst", 1'b0, 5'd0, 32'h0);
        chk("rst.busy",  wb.BUSY_MASK, 32'h0);
        chk("rst.ready", 32'(wb.MUL_READY), 32'd1);
        chk("rst.waw",   32'(wb.WAW_ERR), 32'd0);
        RESET = 1'b1;

        // ALU write, then idle holds address/data, then rd=0 is ignored
        alu(5'd5, 32'hDEADBEEF); step();
        wr("alu5", 1'b1, 5'd5, 32'hDEADBEEF);
        idle_inputs(); step();
        wr("alu5.idle", 1'b0, 5'd5, 32'hDEADBEEF);
        alu(5'd0, 32'h11111111); step();
        wr("alu0", 1'b0, 5'd5, 32'hDEADBEEF);
        idle_inputs();

        // Issue rd7, result arrives 3 cycles later
        wb.QUERY_ADDR1 = 5'd7;
        wb.ISSUE_VALID = 1'b1; wb.ISSUE_RD = 5'd7; step();
        chk("iss7.busy", wb.BUSY_MASK, 32'h0000_0080);
        chk("iss7.p1",   32'(wb.PENDING1), 32'd1);
        chk("iss7.p2",   32'(wb.PENDING2), 32'd0);
        idle_inputs(); step(); step();
        mul(5'd7, 32'h12345678); step();
        chk("mul7.push.we", 32'(wb.WRITE_ENABLE), 32'd0);
        chk("mul7.push.p1", 32'(wb.PENDING1), 32'd1);
        idle_inputs(); step();
        wr("mul7", 1'b1, 5'd7, 32'h12345678);
        chk("mul7.busy", wb.BUSY_MASK, 32'h0);
        chk("mul7.p1",   32'(wb.PENDING1), 32'd0);

        // Collision: ALU holds the port while the FIFO fills
        alu(5'd1, 32'hA1); mul(5'd8, 32'h80); step();
        wr("col1", 1'b1, 5'd1, 32'hA1);
        chk("col1.ready", 32'(wb.MUL_READY), 32'd1);
        alu(5'd2, 32'hA2); mul(5'd9, 32'h90); step();
        wr("col2", 1'b1, 5'd2, 32'hA2);
        chk("col2.ready", 32'(wb.MUL_READY), 32'd0);
        alu(5'd3, 32'hA3); mul(5'd10, 32'h100); step();
        wr("col3", 1'b1, 5'd3, 32'hA3);
        chk("col3.ready", 32'(wb.MUL_READY), 32'd0);
        wb.ALU_VALID = 1'b0; step();
        wr("col8", 1'b1, 5'd8, 32'h80);
        chk("col8.ready", 32'(wb.MUL_READY), 32'd1);
        step();
        wr("col9", 1'b1, 5'd9, 32'h90);
        wb.MUL_VALID = 1'b0; step();
        wr("col10", 1'b1, 5'd10, 32'h100);
        step();
        chk("col.drain.we", 32'(wb.WRITE_ENABLE), 32'd0);
        chk("col.waw", 32'(wb.WAW_ERR), 32'd0);

        // Issue and pop of rd4 in the same cycle: set wins
        mul(5'd4, 32'h44); step();
        idle_inputs(); wb.ISSUE_VALID = 1'b1; wb.ISSUE_RD = 5'd4; step();
        wr("pop4", 1'b1, 5'd4, 32'h44);
        chk("pop4.busy", wb.BUSY_MASK, 32'h0000_0010);
        chk("pop4.waw",  32'(wb.WAW_ERR), 32'd0);
        idle_inputs(); alu(5'd4, 32'h55); step();
        wr("waw4", 1'b1, 5'd4, 32'h55);
        chk("waw4.waw", 32'(wb.WAW_ERR), 32'd1);
        idle_inputs(); step();
        chk("waw.sticky", 32'(wb.WAW_ERR), 32'd1);
        mul(5'd4, 32'h66); step();
        idle_inputs(); step();
        wr("drain4", 1'b1, 5'd4, 32'h66);
        chk("drain4.busy", wb.BUSY_MASK, 32'h0);

        // Two entries held behind ALU traffic, then reset
        wb.QUERY_ADDR2 = 5'd9;
        alu(5'd20, 32'h20); mul(5'd8, 32'h88);
        wb.ISSUE_VALID = 1'b1; wb.ISSUE_RD = 5'd8; step();
        alu(5'd21, 32'h21); mul(5'd9, 32'h99); wb.ISSUE_RD = 5'd9; step();
        chk("full.busy",  wb.BUSY_MASK, 32'h0000_0300);
        chk("full.ready", 32'(wb.MUL_READY), 32'd0);
        chk("full.p2",    32'(wb.PENDING2), 32'd1);
        wr("full", 1'b1, 5'd21, 32'h21);
        idle_inputs(); RESET = 1'b0; step();
        wr("rst2", 1'b0, 5'd0, 32'h0);
        chk("rst2.busy",  wb.BUSY_MASK, 32'h0);
        chk("rst2.ready", 32'(wb.MUL_READY), 32'd1);
        chk("rst2.waw",   32'(wb.WAW_ERR), 32'd0);
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst2.nostale", 32'(wb.WRITE_ENABLE), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
